// File: rtl/crop_bbox_scan.sv
// crop_bbox_scan
// ---------------------------------------------------------------------------
// Streaming per-frame bounding-box extractor. Pixels arrive in raster order,
// qualified by iDVAL. Each pixel is tested against a threshold, with the
// polarity chosen by iPOL, and against a rectangular region of interest. The
// block tracks the min/max column and row of every matching pixel and also
// counts the matches. At the end of each frame it publishes the box, a found
// flag and the count, and pulses oFRAME_DONE.
//
// Ports
//   iCLK            clock
//   iRST            asynchronous active-low reset
//   iDVAL/iDATA     pixel valid / pixel value
//   iSOF            start-of-frame resync: zero the position, drop the
//                   partial frame and reload the configuration
//   iTHRESH, iPOL   threshold and polarity (0: iDATA<=iTHRESH, 1: iDATA>=iTHRESH)
//   iROI_X0/X1/Y0/Y1 inclusive ROI bounds
//   oDVAL           iDVAL delayed by one cycle
//   oXSTART/oXEND/oYSTART/oYEND  box of the last completed frame (0 if none)
//   oFOUND, oCOUNT  match flag and saturating match count of the last frame
//   oFRAME_DONE     one-cycle pulse when the results above update
// ---------------------------------------------------------------------------
module crop_bbox_scan #(
  parameter int DATA_W  = 10,
  parameter int COORD_W = 16,
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480,
  parameter int CNT_W   = 20
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iDVAL,
  input  logic [DATA_W-1:0]  iDATA,
  input  logic               iSOF,
  input  logic [DATA_W-1:0]  iTHRESH,
  input  logic               iPOL,
  input  logic [COORD_W-1:0] iROI_X0,
  input  logic [COORD_W-1:0] iROI_X1,
  input  logic [COORD_W-1:0] iROI_Y0,
  input  logic [COORD_W-1:0] iROI_Y1,
  output logic               oDVAL,
  output logic [COORD_W-1:0] oXSTART,
  output logic [COORD_W-1:0] oXEND,
  output logic [COORD_W-1:0] oYSTART,
  output logic [COORD_W-1:0] oYEND,
  output logic               oFOUND,
  output logic [CNT_W-1:0]   oCOUNT,
  output logic               oFRAME_DONE
);

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_ACT - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(V_ACT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  // Raster position
  logic [COORD_W-1:0] xReg, yReg, xNext, yNext;

  // Per-frame accumulators
  logic [COORD_W-1:0] minXReg, maxXReg, minYReg, maxYReg;
  logic [COORD_W-1:0] minXNext, maxXNext, minYNext, maxYNext;
  logic               foundReg, foundNext;
  logic [CNT_W-1:0]   cntReg, cntNext;

  // Configuration shadows. They are held for a whole frame so that port
  // changes made mid-frame only affect the next frame.
  logic [DATA_W-1:0]  threshReg;
  logic               polReg;
  logic [COORD_W-1:0] roiX0Reg, roiX1Reg, roiY0Reg, roiY1Reg;

  // Set by reset. The shadows then take the port values on the first clock.
  logic               loadPendReg;

  // Effective configuration and position for the current cycle
  logic               reload;
  logic [DATA_W-1:0]  threshCur;
  logic               polCur;
  logic [COORD_W-1:0] roiX0Cur, roiX1Cur, roiY0Cur, roiY1Cur;
  logic [COORD_W-1:0] xCur, yCur;
  logic               levelMatch, inRoi, qualify, lastPix, shadowLoad;

  always_comb begin
    // On a reload cycle the pixel is judged against the incoming config,
    // not the stale shadows, so bypass the shadow registers.
    reload    = loadPendReg | iSOF;
    threshCur = reload ? iTHRESH : threshReg;
    polCur    = reload ? iPOL    : polReg;
    roiX0Cur  = reload ? iROI_X0 : roiX0Reg;
    roiX1Cur  = reload ? iROI_X1 : roiX1Reg;
    roiY0Cur  = reload ? iROI_Y0 : roiY0Reg;
    roiY1Cur  = reload ? iROI_Y1 : roiY1Reg;

    // An SOF pixel is treated as (0,0) in a freshly cleared frame.
    xCur      = iSOF ? '0 : xReg;
    yCur      = iSOF ? '0 : yReg;
    minXNext  = iSOF ? '1 : minXReg;
    maxXNext  = iSOF ? '0 : maxXReg;
    minYNext  = iSOF ? '1 : minYReg;
    maxYNext  = iSOF ? '0 : maxYReg;
    foundNext = iSOF ? 1'b0 : foundReg;
    cntNext   = iSOF ? '0 : cntReg;

    levelMatch = polCur ? (iDATA >= threshCur) : (iDATA <= threshCur);
    inRoi      = (xCur >= roiX0Cur) && (xCur <= roiX1Cur) &&
                 (yCur >= roiY0Cur) && (yCur <= roiY1Cur);
    qualify    = iDVAL && levelMatch && inRoi;

    if (qualify) begin
      if (xCur < minXNext) minXNext = xCur;
      if (xCur > maxXNext) maxXNext = xCur;
      if (yCur < minYNext) minYNext = yCur;
      if (yCur > maxYNext) maxYNext = yCur;
      foundNext = 1'b1;
      if (cntNext != CNT_MAX) cntNext = cntNext + 1'b1;
    end

    lastPix = iDVAL && (xCur == X_LAST) && (yCur == Y_LAST);

    xNext = xCur;
    yNext = yCur;
    if (iDVAL) begin
      if (xCur == X_LAST) begin
        xNext = '0;
        yNext = (yCur == Y_LAST) ? '0 : yCur + 1'b1;
      end else begin
        xNext = xCur + 1'b1;
      end
    end

    shadowLoad = reload | lastPix;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDVAL       <= 1'b0;
      xReg        <= '0;
      yReg        <= '0;
      minXReg     <= '1;
      maxXReg     <= '0;
      minYReg     <= '1;
      maxYReg     <= '0;
      foundReg    <= 1'b0;
      cntReg      <= '0;
      threshReg   <= '0;
      polReg      <= 1'b0;
      roiX0Reg    <= '0;
      roiX1Reg    <= '0;
      roiY0Reg    <= '0;
      roiY1Reg    <= '0;
      loadPendReg <= 1'b1;
      oXSTART     <= '0;
      oXEND       <= '0;
      oYSTART     <= '0;
      oYEND       <= '0;
      oFOUND      <= 1'b0;
      oCOUNT      <= '0;
      oFRAME_DONE <= 1'b0;
    end else begin
      oDVAL       <= iDVAL;
      loadPendReg <= 1'b0;
      xReg        <= xNext;
      yReg        <= yNext;
      oFRAME_DONE <= lastPix;

      if (shadowLoad) begin
        threshReg <= iTHRESH;
        polReg    <= iPOL;
        roiX0Reg  <= iROI_X0;
        roiX1Reg  <= iROI_X1;
        roiY0Reg  <= iROI_Y0;
        roiY1Reg  <= iROI_Y1;
      end

      if (lastPix) begin
        // Publish results that include the last pixel, then start a clean frame.
        oFOUND   <= foundNext;
        oXSTART  <= foundNext ? minXNext : '0;
        oXEND    <= foundNext ? maxXNext : '0;
        oYSTART  <= foundNext ? minYNext : '0;
        oYEND    <= foundNext ? maxYNext : '0;
        oCOUNT   <= foundNext ? cntNext  : '0;
        minXReg  <= '1;
        maxXReg  <= '0;
        minYReg  <= '1;
        maxYReg  <= '0;
        foundReg <= 1'b0;
        cntReg   <= '0;
      end else begin
        minXReg  <= minXNext;
        maxXReg  <= maxXNext;
        minYReg  <= minYNext;
        maxYReg  <= maxYNext;
        foundReg <= foundNext;
        cntReg   <= cntNext;
      end
    end
  end

endmodule

// File: tb/tb_crop_bbox_scan.sv
// Bench for crop_bbox_scan. It uses a small raster so that whole frames stay
// short, and a narrow match counter so that saturation can be reached.
module tb_crop_bbox_scan;
  localparam int DATA_W  = 10;
  localparam int COORD_W = 16;
  localparam int H_ACT   = 16;
  localparam int V_ACT   = 12;
  localparam int CNT_W   = 6;
  localparam int NPIX    = H_ACT * V_ACT;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               iCLK = 1'b0;
  logic               iRST = 1'b0;
  logic               iDVAL = 1'b0;
  logic               iSOF = 1'b0;
  logic               iPOL = 1'b0;
  logic [DATA_W-1:0]  iDATA = '0;
  logic [DATA_W-1:0]  iTHRESH = '0;
  logic [COORD_W-1:0] iROI_X0 = '0, iROI_X1 = '0, iROI_Y0 = '0, iROI_Y1 = '0;
  logic               oDVAL, oFOUND, oFRAME_DONE;
  logic [COORD_W-1:0] oXSTART, oXEND, oYSTART, oYEND;
  logic [CNT_W-1:0]   oCOUNT;

  crop_bbox_scan #(.DATA_W(DATA_W), .COORD_W(COORD_W), .H_ACT(H_ACT),
                   .V_ACT(V_ACT), .CNT_W(CNT_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iDATA(iDATA), .iSOF(iSOF),
    .iTHRESH(iTHRESH), .iPOL(iPOL),
    .iROI_X0(iROI_X0), .iROI_X1(iROI_X1), .iROI_Y0(iROI_Y0), .iROI_Y1(iROI_Y1),
    .oDVAL(oDVAL), .oXSTART(oXSTART), .oXEND(oXEND), .oYSTART(oYSTART),
    .oYEND(oYEND), .oFOUND(oFOUND), .oCOUNT(oCOUNT), .oFRAME_DONE(oFRAME_DONE)
  );

  always #5 iCLK = ~iCLK;

  int tests = 0;
  int failed = 0;
  int doneCnt = 0;
  int img[NPIX];
  int mXs, mXe, mYs, mYe, mFound, mCnt;

  typedef struct {
    int bg; int thr; int pol;
    int x0; int x1; int y0; int y1;
    int ax; int ay; int bx; int by; int cx; int cy; int pv;
    int exs; int exe; int eys; int eye; int efound; int ecnt;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input integer act, input integer exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock. Outputs are sampled 1 ns after the edge and oDVAL is checked
  // against the iDVAL value that edge sampled.
  task automatic tick();
    logic expDval;
    expDval = iDVAL;
    @(posedge iCLK);
    #1;
    if (!iRST) expDval = 1'b0;
    chk("oDVAL", oDVAL, expDval);
    if (oFRAME_DONE) doneCnt++;
  endtask

  task automatic setCfg(input int thr, input int pol, input int x0, input int x1,
                        input int y0, input int y1);
    iTHRESH = DATA_W'(thr);
    iPOL    = (pol != 0);
    iROI_X0 = COORD_W'(x0);
    iROI_X1 = COORD_W'(x1);
    iROI_Y0 = COORD_W'(y0);
    iROI_Y1 = COORD_W'(y1);
  endtask

  task automatic fillImg(input int bg);
    for (int i = 0; i < NPIX; i++) img[i] = bg;
  endtask

  task automatic setPix(input int x, input int y, input int v);
    if (x >= 0 && y >= 0) img[y * H_ACT + x] = v;
  endtask

  task automatic sofPulse();
    iDVAL = 1'b0;
    iSOF  = 1'b1;
    tick();
    iSOF  = 1'b0;
  endtask

  // Drive raster indices from..to, with random blanking gaps.
  task automatic sendPixels(input int from, input int to, input int gapPct);
    for (int i = from; i <= to; i++) begin
      if (int'($urandom_range(0, 99)) < gapPct) begin
        iDVAL = 1'b0;
        repeat (int'($urandom_range(1, 3))) tick();
      end
      iDVAL = 1'b1;
      iDATA = DATA_W'(img[i]);
      tick();
    end
    iDVAL = 1'b0;
  endtask

  task automatic checkBox(input string tag, input int xs, input int xe, input int ys,
                          input int ye, input int f, input int c);
    chk({tag, " oXSTART"}, oXSTART, xs);
    chk({tag, " oXEND"}, oXEND, xe);
    chk({tag, " oYSTART"}, oYSTART, ys);
    chk({tag, " oYEND"}, oYEND, ye);
    chk({tag, " oFOUND"}, oFOUND, f);
    chk({tag, " oCOUNT"}, oCOUNT, c);
  endtask

  // Checks taken right after the last pixel's edge: the done pulse is there,
  // there was exactly one pulse, and it clears on the next cycle.
  task automatic checkDone(input string tag, input int xs, input int xe, input int ys,
                           input int ye, input int f, input int c);
    chk({tag, " done"}, oFRAME_DONE, 1);
    chk({tag, " pulses"}, doneCnt, 1);
    checkBox(tag, xs, xe, ys, ye, f, c);
    tick();
    chk({tag, " done width"}, oFRAME_DONE, 0);
    checkBox({tag, " hold"}, xs, xe, ys, ye, f, c);
  endtask

  task automatic runFrame(input string tag, input int xs, input int xe, input int ys,
                          input int ye, input int f, input int c);
    sofPulse();
    doneCnt = 0;
    sendPixels(0, NPIX - 1, 20);
    checkDone(tag, xs, xe, ys, ye, f, c);
  endtask

  // Reference result, computed directly from the image and the frame config.
  task automatic modelFrame(input int thr, input int pol, input int x0, input int x1,
                            input int y0, input int y1);
    bit m;
    mFound = 0; mCnt = 0;
    mXs = H_ACT; mXe = -1; mYs = V_ACT; mYe = -1;
    for (int y = 0; y < V_ACT; y++) begin
      for (int x = 0; x < H_ACT; x++) begin
        m = (pol != 0) ? (img[y * H_ACT + x] >= thr) : (img[y * H_ACT + x] <= thr);
        if (m && x >= x0 && x <= x1 && y >= y0 && y <= y1) begin
          mFound = 1;
          mCnt++;
          if (x < mXs) mXs = x;
          if (x > mXe) mXe = x;
          if (y < mYs) mYs = y;
          if (y > mYe) mYe = y;
        end
      end
    end
    if (mCnt > CNT_MAX) mCnt = CNT_MAX;
    if (mFound == 0) begin
      mXs = 0; mXe = 0; mYs = 0; mYe = 0;
    end
  endtask

  initial begin
    vec_t v;
    int thr, pol, x0, x1, y0, y1, np;

    //          bg  thr  pol x0  x1  y0  y1  ax ay bx by cx cy pv  xs xe ys ye f  cnt
    vecs[0] = '{1023,  0, 0, 0, 15,  0, 11,  3, 2,11, 7,-1,-1,  0,  3,11, 2, 7,1, 2};
    vecs[1] = '{1023,  0, 0, 4, 12,  1,  9,  5, 2,11, 7, 2, 5,  0,  5,11, 2, 7,1, 2};
    vecs[2] = '{1023,  0, 0, 0, 15,  0, 11, -1,-1,-1,-1,-1,-1,  0,  0, 0, 0, 0,0, 0};
    vecs[3] = '{1023,1000,1, 0, 15,  0, 11, -1,-1,-1,-1,-1,-1,  0,  0,15, 0,11,1,63};
    vecs[4] = '{1023,  0, 0,10,  5,  0, 11,  7, 3, 8, 4,-1,-1,  0,  0, 0, 0, 0,0, 0};
    vecs[5] = '{1023,  0, 0, 0,100,  0,200, 15,11, 0, 0,-1,-1,  0,  0,15, 0,11,1, 2};
    vecs[6] = '{ 100,500, 1, 0, 15,  0, 11,  7, 7, 8, 3,-1,-1,500,  7, 8, 3, 7,1, 2};
    vecs[7] = '{ 201,200, 0, 0, 15,  0, 11,  0,11,15, 0,-1,-1,200,  0,15, 0,11,1, 2};
    vecs[8] = '{   5,  0, 1, 6,  6,  6,  6, -1,-1,-1,-1,-1,-1,  0,  6, 6, 6, 6,1, 1};

    // Reset state
    setCfg(0, 0, 0, 15, 0, 11);
    #12;
    chk("reset oDVAL", oDVAL, 0);
    chk("reset oFRAME_DONE", oFRAME_DONE, 0);
    checkBox("reset", 0, 0, 0, 0, 0, 0);
    #1 iRST = 1'b1;

    // Table-driven frames
    for (int k = 0; k < 9; k++) begin
      v = vecs[k];
      setCfg(v.thr, v.pol, v.x0, v.x1, v.y0, v.y1);
      fillImg(v.bg);
      setPix(v.ax, v.ay, v.pv);
      setPix(v.bx, v.by, v.pv);
      setPix(v.cx, v.cy, v.pv);
      runFrame($sformatf("vec%0d", k), v.exs, v.exe, v.eys, v.eye, v.efound, v.ecnt);
    end

    // Mid-frame config change: this frame keeps the old config, the next
    // frame picks up the new one.
    setCfg(0, 0, 0, 15, 0, 11);
    fillImg(1023);
    setPix(3, 3, 0);
    setPix(8, 8, 600);
    sofPulse();
    doneCnt = 0;
    sendPixels(0, 95, 20);
    setCfg(600, 0, 5, 15, 0, 11);
    sendPixels(96, NPIX - 1, 20);
    checkDone("cfg old", 3, 3, 3, 3, 1, 1);
    doneCnt = 0;
    sendPixels(0, NPIX - 1, 20);
    checkDone("cfg new", 8, 8, 8, 8, 1, 1);

    // SOF abort: the partial frame holding (10,1) is dropped without a pulse.
    setCfg(0, 0, 0, 15, 0, 11);
    fillImg(1023);
    setPix(10, 1, 0);
    sofPulse();
    doneCnt = 0;
    sendPixels(0, 39, 20);
    chk("sof partial pulses", doneCnt, 0);
    fillImg(1023);
    setPix(4, 4, 0);
    sofPulse();
    sendPixels(0, NPIX - 1, 20);
    checkDone("sof abort", 4, 4, 4, 4, 1, 1);

    // SOF together with a valid matching pixel. The old shadows exclude
    // column 0; the new ROI presented in that cycle includes it.
    setCfg(0, 0, 5, 15, 0, 11);
    fillImg(1023);
    sofPulse();
    doneCnt = 0;
    sendPixels(0, 49, 20);
    setCfg(0, 0, 0, 15, 0, 11);
    setPix(9, 9, 0);
    iSOF  = 1'b1;
    iDVAL = 1'b1;
    iDATA = '0;
    tick();
    iSOF  = 1'b0;
    sendPixels(1, NPIX - 1, 20);
    checkDone("sof+dval", 0, 9, 0, 9, 1, 2);

    // Asynchronous reset mid-frame, with iDVAL still high.
    fillImg(1023);
    sendPixels(0, 29, 0);
    iDVAL = 1'b1;
    #3 iRST = 1'b0;
    #1;
    chk("async rst oDVAL", oDVAL, 0);
    chk("async rst oFRAME_DONE", oFRAME_DONE, 0);
    checkBox("async rst", 0, 0, 0, 0, 0, 0);
    iDVAL = 1'b0;
    repeat (2) @(posedge iCLK);
    #4 iRST = 1'b1;
    setPix(2, 9, 0);
    doneCnt = 0;
    sendPixels(0, NPIX - 1, 10);
    checkDone("after rst", 2, 2, 9, 9, 1, 1);

    // Randomised frames checked against the reference model
    for (int r = 0; r < 16; r++) begin
      thr = int'($urandom_range(1, 1022));
      pol = int'($urandom_range(0, 1));
      x0  = int'($urandom_range(0, 18));
      x1  = int'($urandom_range(0, 18));
      y0  = int'($urandom_range(0, 14));
      y1  = int'($urandom_range(0, 14));
      if (r % 4 == 0) begin
        x0 = 0; x1 = H_ACT - 1; y0 = 0; y1 = V_ACT - 1;
      end
      if (r % 2 == 0) begin
        for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 1023));
      end else begin
        fillImg((pol != 0) ? 0 : 1023);
        np = int'($urandom_range(0, 4));
        for (int p = 0; p < np; p++)
          setPix(int'($urandom_range(0, H_ACT - 1)), int'($urandom_range(0, V_ACT - 1)),
                 int'($urandom_range(0, 1023)));
      end
      setCfg(thr, pol, x0, x1, y0, y1);
      modelFrame(thr, pol, x0, x1, y0, y1);
      runFrame($sformatf("rand%0d", r), mXs, mXe, mYs, mYe, mFound, mCnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/crop_bbox_scan.md
Name: crop_bbox_scan

Overview:
- Streaming per-frame bounding-box extractor.
- Scans a raster of H_ACT x V_ACT pixels, qualified by iDVAL, and tracks the min/max X and Y of pixels that match a threshold test inside a runtime-programmable ROI.
- Publishes the box, a found flag and a match count once per frame.
- Sits after the sensor/grey conversion stage and feeds the crop/capture controller. Generalises the single-edge XEND finder to a full 4-edge box with selectable polarity.

Parameters:
DATA_W, 10, pixel data width
COORD_W, 16, width of X/Y counters and all coordinate ports
H_ACT, 640, active pixels per line
V_ACT, 480, active lines per frame
CNT_W, 20, width of match-pixel counter (saturating)

Ports:
iCLK  in  1  clock
iRST  in  1  asynchronous active-low reset
iDVAL  in  1  pixel valid
iDATA  in  DATA_W  pixel value
iSOF  in  1  start-of-frame resync strobe
iTHRESH  in  DATA_W  match threshold
iPOL  in  1  0: match when iDATA<=iTHRESH (dark); 1: match when iDATA>=iTHRESH (bright)
iROI_X0, iROI_X1  in  COORD_W  inclusive ROI column bounds
iROI_Y0, iROI_Y1  in  COORD_W  inclusive ROI row bounds
oDVAL  out  1  iDVAL delayed one cycle
oXSTART, oXEND  out  COORD_W  min/max matching column of last completed frame
oYSTART, oYEND  out  COORD_W  min/max matching row of last completed frame
oFOUND  out  1  at least one match in last completed frame
oCOUNT  out  CNT_W  matching-pixel count of last completed frame
oFRAME_DONE  out  1  one-cycle pulse when results update

Behaviour:
- Reset (iRST low, async):
  - All outputs and counters go to 0.
  - Accumulators: min=all-ones, max=0, found=0, count=0.
  - ROI and threshold shadows load from the ports on the first clock after reset release.
- Coordinate counters X, Y:
  - Advance only on cycles with iDVAL=1.
  - X increments; at X=H_ACT-1, X wraps to 0 and Y increments.
  - At X=H_ACT-1 and Y=V_ACT-1 the frame completes and both wrap to 0.
- Pixel qualifies when all of the following hold:
  - iDVAL=1
  - the threshold test per iPOL is true
  - shadow X0<=X<=X1 and shadow Y0<=Y<=Y1
- On a qualifying pixel:
  - min_x=min(min_x,X), max_x=max(max_x,X), and likewise for Y.
  - found=1.
  - count increments, saturating at 2^CNT_W-1.
- Frame completion, cycle N = the last pixel's valid cycle:
  - At edge N+1 the outputs register final values that include pixel N. oFRAME_DONE=1 for exactly that one cycle.
  - If found=0, the four coordinate outputs and oCOUNT are driven to 0 and oFOUND=0.
  - In the same cycle, accumulators reinitialise and the ROI/iTHRESH/iPOL shadows reload. Config changes mid-frame therefore take effect at the next frame.
- Outputs hold between completions.
- oDVAL: registered copy of iDVAL, latency 1, independent of all other logic.
- iSOF=1:
  - X and Y force to 0 and accumulators reinitialise, with no output update and no oFRAME_DONE.
  - Shadows reload.
  - If iDVAL=1 in the same cycle, that pixel is processed as (0,0) against the new shadows: reload and match are combined, with the new config taking priority.
- Inverted ROI (X0>X1 or Y0>Y1): nothing qualifies, so oFOUND=0 at frame end.
- ROI bounds beyond H_ACT-1/V_ACT-1 are clipped naturally by the counter range.
- Gaps in iDVAL (blanking) pause counting; there is no timeout.
- Reset mid-frame discards the partial frame; outputs return to reset values.
- Arithmetic:
  - All compares are unsigned.
  - Counters are COORD_W wide; H_ACT and V_ACT must be <= 2^COORD_W.
  - Single clock domain, fully synchronous except reset.

Test Plan:
1. Default params, ROI 0..639/0..479, POL=0, THRESH=0; one frame of data=1023 except pixels (200,130)=0 and (450,185)=0 -> after last pixel: oFRAME_DONE pulse, oXSTART=200, oXEND=450, oYSTART=130, oYEND=185, oCOUNT=2, oFOUND=1.
2. Same image, ROI X 161..479 / Y 121..189, with a match at (100,150) added -> the (100,150) match is excluded; box 200..450/130..185, count 2.
3. All-bright frame, POL=0, THRESH=0 -> oFOUND=0, all coords 0, oCOUNT=0. Then a frame with POL=1, THRESH=1000 -> box 0..639/0..479, count 307200.
4. Change ROI and THRESH mid-frame -> the current frame's result uses the old config; the next frame uses the new config.
5. Assert iSOF at pixel ~1000 of a frame containing a match at (10,1), then send a full frame -> no oFRAME_DONE for the aborted partial; the result reflects only the full frame. Also check iSOF with iDVAL in the same cycle, with that pixel matching -> it counts as (0,0).
6. Deassert iRST mid-frame -> all outputs 0 immediately (async). oDVAL tracks iDVAL with 1-cycle latency throughout, including across iDVAL gaps.
